// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and load/store (DM) requesters.
// DM has priority; a streak counter bounds fetch starvation; done pulses one cycle after the memory completes.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q;
  logic              owner_dm_q;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;
  logic              dm_wins;
  logic              capture;

  assign any_req = if_req | dm_req;
  assign dm_wins = dm_req & (~if_req | (streak_q < STREAK_MAX));
  // Read data is taken either on a fused ack+done in ISSUE or on done in WAIT.
  assign capture = ((state_q == ISSUE) & mem_ack & mem_done) |
                   ((state_q == WAIT) & mem_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      owner_dm_q <= 1'b0;
      rdata_q    <= '0;
      mem_we     <= 1'b0;
      mem_size   <= 3'b000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && any_req) begin
        owner_dm_q <= dm_wins;
        if (dm_wins) begin
          mem_we    <= dm_we;
          mem_size  <= dm_size;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          if (!if_req)
            streak_q <= '0;
          else if (streak_q != STREAK_MAX)
            streak_q <= streak_q + 1'b1;
        end else begin
          mem_we    <= 1'b0;
          mem_size  <= 3'b010;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          streak_q  <= '0;
        end
      end
      if (capture)
        rdata_q <= mem_we ? '0 : mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (mem_ack) state_d = mem_done ? RESP : WAIT;
      WAIT:    if (mem_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state_q == ISSUE);
    if_done  = (state_q == RESP) & ~owner_dm_q;
    dm_done  = (state_q == RESP) & owner_dm_q;
    if_rdata = if_done ? rdata_q : '0;
    dm_rdata = dm_done ? rdata_q : '0;
    if_stall = if_req & ~if_done;
    dm_stall = dm_req & ~dm_done;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scripted memory responder and hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_done;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for mem_req, acks it (optionally fused with done), and returns at the
  // negedge where the requester's done pulse should be visible.
  task automatic mem_serve(input logic [31:0] rd, input bit fused,
                           output logic [31:0] addr, output logic we,
                           output logic [2:0] sz, output logic [31:0] wd);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) chk_eq("mem_req_timeout", 64'd0, 64'd1);
    addr = mem_addr;
    we   = mem_we;
    sz   = mem_size;
    wd   = mem_wdata;
    mem_ack = 1'b1;
    if (fused) begin
      mem_done  = 1'b1;
      mem_rdata = rd;
    end
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_done = 1'b0;
    if (!fused) begin
      chk_eq("mem_req_fall", {63'd0, mem_req}, 64'd0);
      @(negedge clk);
      mem_done  = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_done  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, w;
    logic        we;
    logic [2:0]  sz;
    int          t0;
    bit          exp_dm;

    reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_size = 0;
    dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_done = 0; mem_rdata = 0;
    @(negedge clk); @(negedge clk);
    chk_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk_eq("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk_eq("rst_dones", {62'd0, if_done, dm_done}, 64'd0);
    chk_eq("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    reset = 1'b0;

    // 1: fetch only, ack in cycle 1, done in cycle 3
    if_addr = 32'h100; if_req = 1'b1;
    #1 chk_eq("t1_if_stall", {63'd0, if_stall}, 64'd1);
    mem_serve(32'h00500093, 0, a, we, sz, w);
    chk_eq("t1_addr", {32'd0, a}, 64'h100);
    chk_eq("t1_we_sz_wd", {28'd0, we, sz, w}, {28'd0, 1'b0, 3'b010, 32'd0});
    chk_eq("t1_if_done", {63'd0, if_done}, 64'd1);
    chk_eq("t1_if_rdata", {32'd0, if_rdata}, 64'h00500093);
    chk_eq("t1_dm_done", {63'd0, dm_done}, 64'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk_eq("t1_single_pulse", {63'd0, if_done}, 64'd0);

    // 2: simultaneous requests, DM first then IF
    if_addr = 32'h104; if_req = 1'b1;
    dm_addr = 32'h10010; dm_we = 1'b0; dm_size = 3'b010; dm_req = 1'b1;
    mem_serve(32'hAAAA5555, 0, a, we, sz, w);
    chk_eq("t2_first_addr", {32'd0, a}, 64'h10010);
    chk_eq("t2_dm_done", {62'd0, dm_done, if_done}, 64'b10);
    chk_eq("t2_dm_rdata", {32'd0, dm_rdata}, 64'hAAAA5555);
    chk_eq("t2_no_overlap", {63'd0, mem_req}, 64'd0);
    dm_req = 1'b0;
    mem_serve(32'h11112222, 0, a, we, sz, w);
    chk_eq("t2_second_addr", {32'd0, a}, 64'h104);
    chk_eq("t2_if_done", {62'd0, dm_done, if_done}, 64'b01);
    chk_eq("t2_if_rdata", {32'd0, if_rdata}, 64'h11112222);

    // 3: if_req held, dm_req renewed; expected order DM,DM,DM,DM,IF,DM,DM
    if_addr = 32'h200;
    dm_addr = 32'h20000; dm_req = 1'b1;
    for (int g = 0; g < 7; g++) begin
      exp_dm = (g != 4);
      mem_serve(32'h5000 + g, 0, a, we, sz, w);
      chk_eq($sformatf("t3_grant%0d", g), {32'd0, a}, exp_dm ? {32'd0, dm_addr} : 64'h200);
      chk_eq($sformatf("t3_done%0d", g), {62'd0, dm_done, if_done}, exp_dm ? 64'b10 : 64'b01);
      if (exp_dm) dm_addr = dm_addr + 32'd4;
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);

    // 4: byte store
    dm_we = 1'b1; dm_size = 3'b000; dm_addr = 32'h10004; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
    mem_serve(32'h12345678, 0, a, we, sz, w);
    chk_eq("t4_addr", {32'd0, a}, 64'h10004);
    chk_eq("t4_we_sz", {60'd0, we, sz}, {60'd0, 1'b1, 3'b000});
    chk_eq("t4_wdata", {32'd0, w}, 64'hDEADBEEF);
    chk_eq("t4_dm_done_rdata", {31'd0, dm_done, dm_rdata}, {31'd0, 1'b1, 32'd0});
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 0;
    @(negedge clk);

    // 5: reset while WAIT, stale mem_done afterwards
    if_addr = 32'h300; if_req = 1'b1;
    @(negedge clk);
    chk_eq("t5_issue", {63'd0, mem_req}, 64'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_done = 1'b1; mem_rdata = 32'hBAD0BAD0;
    chk_eq("t5_rst_mem", {30'd0, mem_req, mem_we, mem_addr}, 64'd0);
    chk_eq("t5_rst_dones", {62'd0, if_done, dm_done}, 64'd0);
    @(negedge clk);
    mem_done = 1'b0;
    chk_eq("t5_no_stale_done", {62'd0, if_done, dm_done}, 64'd0);
    chk_eq("t5_rearb", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h300});
    mem_serve(32'hCAFE0001, 0, a, we, sz, w);
    chk_eq("t5_if_done", {31'd0, if_done, if_rdata}, {31'd0, 1'b1, 32'hCAFE0001});
    if_req = 1'b0;
    @(negedge clk);

    // 6: fused ack+done, requester drops req early; done still pulses
    dm_addr = 32'h10020; dm_we = 1'b0; dm_size = 3'b010; dm_req = 1'b1;
    t0 = cyc;
    @(negedge clk);
    dm_req = 1'b0;
    mem_serve(32'h0BADF00D, 1, a, we, sz, w);
    chk_eq("t6_addr", {32'd0, a}, 64'h10020);
    // done sits in the third cycle: two clock edges after the req was first sampled
    chk_eq("t6_latency", 64'(cyc - t0), 64'd2);
    chk_eq("t6_dm_done", {31'd0, dm_done, dm_rdata}, {31'd0, 1'b1, 32'h0BADF00D});
    chk_eq("t6_if_done", {63'd0, if_done}, 64'd0);
    @(negedge clk);
    chk_eq("t6_single_pulse", {63'd0, dm_done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
